adc_serial_if: RTL

- ADC-side responder for the `adc_data_req` / `adc_data_rdy` / `adc_data` handshake consumed by `data_acquire`.
- On each request it runs one serial read frame from an external SPI-style ADC (chip select, serial clock, serial data in).
- It presents the received 12-bit two's-complement sample and reasserts ready.
- It sits between the ADC pins and `data_acquire`, which averages the samples.

---
 rtl/adc_serial_if.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/adc_serial_if.sv
// ADC-side responder: one SPI-style read frame per request edge,
// presenting the low DATA_W bits as the sample with a ready flag.
module adc_serial_if #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int QUIET      = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              adc_data_req_i,
  output logic              adc_data_rdy_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              adc_ovr_o,
  output logic              adc_cs_n_o,
  output logic              adc_sclk_o,
  input  logic              adc_sdo_i
);

  localparam int PER  = 2 * CLK_DIV;
  localparam int MX0  = (CS_SETUP > QUIET) ? CS_SETUP : QUIET;
  localparam int MAXC = (MX0 > PER) ? MX0 : PER;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] QUIET_END = CW'(QUIET - 1);
  localparam logic [CW-1:0] HI_START  = CW'(CLK_DIV);
  localparam logic [CW-1:0] PER_END   = CW'(PER - 1);
  localparam logic [BW-1:0] BITS_END  = BW'(FRAME_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_QUIET
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        ovr_q, ovr_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        req_edge;
  logic        start;

  assign req_edge = adc_data_req_i & ~req_q;

  always_comb begin
    state_d = state_q;
    req_d   = adc_data_req_i;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ovr_d   = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    start   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start = req_edge;
      end
      S_SETUP: begin
        ovr_d = req_edge;
        if (cnt_q == SETUP_END) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (bit_q == BITS_END) begin
          // an edge on the completing cycle queues like a QUIET request
          state_d = S_QUIET;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          rdy_d   = 1'b1;
          data_d  = shift_q;
          pend_d  = req_edge;
        end else begin
          ovr_d = req_edge;
          if (cnt_q == '0)
            sclk_d = 1'b0;
          if (cnt_q == HI_START) begin
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1)
                    | DATA_W'(adc_sdo_i);
          end
          if (cnt_q == PER_END) begin
            cnt_d = '0;
            bit_d = bit_q + BW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_QUIET: begin
        ovr_d = req_edge & pend_q;
        if (req_edge)
          pend_d = 1'b1;
        if (cnt_q == QUIET_END) begin
          start   = pend_q | req_edge;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_SETUP;
      pend_d  = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = '0;
      rdy_d   = 1'b0;
      cs_n_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b1;
      ovr_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  assign adc_data_rdy_o = rdy_q;
  assign adc_data_o     = data_q;
  assign adc_ovr_o      = ovr_q;
  assign adc_cs_n_o     = cs_n_q;
  assign adc_sclk_o     = sclk_q;

endmodule
